// File: rtl/cva5_types.sv
// ============================================================================
//  Module      : cva5_types (package)
//  Description : Shared types and constants for the writeback group arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cva5_types;

    // Width of each per-unit saturating stall counter
    localparam int WB_ARB_STALL_W = 16;

    // Field widths of the packed result record at the default configuration
    localparam int WB_ARB_ID_W   = 3;
    localparam int WB_ARB_DATA_W = 32;
    localparam int WB_ARB_UNIT_W = 3;

    // One granted result as it travels to the writeback port
    typedef struct packed {
        logic [WB_ARB_ID_W-1:0]   id;
        logic [WB_ARB_DATA_W-1:0] data;
        logic [WB_ARB_UNIT_W-1:0] unit;
    } wb_arb_result_t;

endpackage : cva5_types

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
//  Module      : rr_priority_picker
//  Description : Combinational round-robin picker. Rotates the request vector
//                so the slot after last_grant lands at bit 0, priority-encodes
//                the lowest set bit, then maps the offset back to a unit index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
    import cva5_types::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    logic [N-1:0] rotated;
    int unsigned  start;
    int unsigned  offset;
    int unsigned  winner;

    // Double-width rotate, lowest-set-bit encode, and map back to an index
    always_comb begin
        start   = (32'(last_grant) + 32'd1) % 32'(N);
        rotated = N'({req, req} >> start);
        offset  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = 32'(i);
            end
        end
        winner = (start + offset) % 32'(N);
        valid  = |rotated;
        index  = IDX_W'(winner);
        grant  = valid ? (N'(1) << winner) : '0;
    end

endmodule : rr_priority_picker

`default_nettype wire

// File: rtl/wb_group_arbiter.sv
// ============================================================================
//  Module      : wb_group_arbiter
//  Description : Round-robin arbiter sharing one registered writeback port
//                among the units of a writeback group. Acks the granted unit
//                combinationally and holds the port while it is stalled.
//                Optional feature macro: WB_ARB_STALL_COUNT_EN builds the
//                per-unit saturating stall counters; otherwise they read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_group_arbiter
    import cva5_types::*;
#(
    parameter int NUM_UNITS = 5,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_UNITS-1:0]                unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]           unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0]         unit_rd,
    output logic [NUM_UNITS-1:0]                unit_ack,
    output logic                                wb_valid,
    output logic [ID_W-1:0]                     wb_id,
    output logic [DATA_W-1:0]                   wb_data,
    output logic [$clog2(NUM_UNITS)-1:0]        wb_unit,
    input  logic                                wb_ready,
    input  logic                                perf_clear,
    output logic [NUM_UNITS*WB_ARB_STALL_W-1:0] stall_count
);

    localparam int IDX_W = $clog2(NUM_UNITS);

    logic                 load;
    logic [IDX_W-1:0]     last_grant;
    logic [NUM_UNITS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_index;
    logic                 pick_valid;
    logic [ID_W-1:0]      sel_id;
    logic [DATA_W-1:0]    sel_data;

    // The port can take a new result when empty or being drained this cycle
    assign load     = !wb_valid || wb_ready;
    assign unit_ack = pick_grant & {NUM_UNITS{load}};

    rr_priority_picker #(
        .N     (NUM_UNITS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (unit_done),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .index      (pick_index),
        .valid      (pick_valid)
    );

    // Mux the winning unit's id and data
    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (pick_index == IDX_W'(i)) begin
                sel_id   = unit_id[i*ID_W +: ID_W];
                sel_data = unit_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output register and round-robin pointer; pointer moves only on an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_id      <= '0;
            wb_data    <= '0;
            wb_unit    <= '0;
            last_grant <= IDX_W'(NUM_UNITS - 1);
        end else if (load) begin
            if (pick_valid) begin
                wb_valid   <= 1'b1;
                wb_id      <= sel_id;
                wb_data    <= sel_data;
                wb_unit    <= pick_index;
                last_grant <= pick_index;
            end else begin
                wb_valid   <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_STALL_COUNT_EN
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_stall_cnt
        logic [WB_ARB_STALL_W-1:0] cnt;

        // Count cycles a unit waits with a pending result; clear wins, saturate at max
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (perf_clear) begin
                cnt <= '0;
            end else if (unit_done[g] && !unit_ack[g] && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stall_count[g*WB_ARB_STALL_W +: WB_ARB_STALL_W] = cnt;
    end
`else
    logic unused_perf_clear;
    assign unused_perf_clear = perf_clear;
    assign stall_count       = '0;
`endif

endmodule : wb_group_arbiter

`default_nettype wire

// File: tb/tb_wb_group_arbiter.sv
// ============================================================================
//  Module      : tb_wb_group_arbiter
//  Description : Directed self-checking bench for wb_group_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_group_arbiter;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int DW = 32;
    localparam int SW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      unit_done = '0;
    logic [N*IW-1:0]   unit_id = '0;
    logic [N*DW-1:0]   unit_rd = '0;
    logic [N-1:0]      unit_ack;
    logic              wb_valid;
    logic [IW-1:0]     wb_id;
    logic [DW-1:0]     wb_data;
    logic [2:0]        wb_unit;
    logic              wb_ready = 1'b0;
    logic              perf_clear = 1'b0;
    logic [N*SW-1:0]   stall_count;

    int checks   = 0;
    int failures = 0;

    wb_group_arbiter #(
        .NUM_UNITS (N),
        .ID_W      (IW),
        .DATA_W    (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .unit_done   (unit_done),
        .unit_id     (unit_id),
        .unit_rd     (unit_rd),
        .unit_ack    (unit_ack),
        .wb_valid    (wb_valid),
        .wb_id       (wb_id),
        .wb_data     (wb_data),
        .wb_unit     (wb_unit),
        .wb_ready    (wb_ready),
        .perf_clear  (perf_clear),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Unit i carries id i+1 and data 0xA000000i
        for (int i = 0; i < N; i++) begin
            unit_id[i*IW +: IW] = IW'(i + 1);
            unit_rd[i*DW +: DW] = 32'hA000_0000 | 32'(i);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", wb_valid, 0);
        check("rst_id",    wb_id,    0);
        check("rst_data",  wb_data,  0);
        check("rst_unit",  wb_unit,  0);
        check("rst_ack",   unit_ack, 0);
        check("rst_stall", stall_count, 0);

        // Full contention: ack order 0,1,2,3,4,0 with wb_unit one cycle behind
        rst_n     = 1'b1;
        wb_ready  = 1'b1;
        unit_done = 5'b11111;
        #1;
        check("fc_ack0", unit_ack, 5'b00001);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("fc_ack",   unit_ack, 5'b00001 << (k % 5));
            check("fc_valid", wb_valid, 1);
            check("fc_unit",  wb_unit,  (k - 1) % 5);
            check("fc_data",  wb_data,  32'hA000_0000 | 32'((k - 1) % 5));
        end
        tick();
        check("fc_unit_last", wb_unit, 0);
        check("fc_id_last",   wb_id,   1);

        // Back-pressure: three stalled cycles hold everything
        wb_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("bp_ack",   unit_ack, 0);
            check("bp_valid", wb_valid, 1);
            check("bp_unit",  wb_unit,  0);
            check("bp_id",    wb_id,    1);
            check("bp_data",  wb_data,  32'hA000_0000);
            tick();
        end
        wb_ready = 1'b1;
        #1;
        check("bp_resume_ack", unit_ack, 5'b00010);
        tick();
        check("bp_resume_unit", wb_unit, 1);
        check("bp_resume_id",   wb_id,   2);

        // Sparse / wrap: bring last_grant to 3, then requests 0 and 2
        unit_done = 5'b01000;
        #1;
        check("sp_ack3", unit_ack, 5'b01000);
        tick();
        check("sp_unit3", wb_unit, 3);
        unit_done = 5'b00101;
        #1;
        check("sp_ack0", unit_ack, 5'b00001);
        tick();
        check("sp_unit0", wb_unit, 0);
        check("sp_ack2", unit_ack, 5'b00100);
        tick();
        check("sp_unit2", wb_unit, 2);
        check("sp_data2", wb_data, 32'hA000_0002);
        unit_done = 5'b00000;
        #1;
        check("idle_ack", unit_ack, 0);
        tick();
        check("idle_valid", wb_valid, 0);
        check("idle_unit_stale", wb_unit, 2);
        check("idle_data_stale", wb_data, 32'hA000_0002);

        // Single requester: unit 4 with id 6 and 0xDEADBEEF
        unit_id[4*IW +: IW] = 3'h6;
        unit_rd[4*DW +: DW] = 32'hDEAD_BEEF;
        unit_done = 5'b10000;
        #1;
        check("single_ack", unit_ack, 5'b10000);
        tick();
        check("single_valid", wb_valid, 1);
        check("single_id",    wb_id,    3'h6);
        check("single_data",  wb_data,  32'hDEAD_BEEF);
        check("single_unit",  wb_unit,  4);
        check("single_ack_again", unit_ack, 5'b10000);

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", wb_valid, 0);
        check("arst_data",  wb_data,  0);
        check("arst_unit",  wb_unit,  0);
        @(negedge clk);
        rst_n     = 1'b1;
        unit_done = 5'b11111;
        #1;
        check("arst_first_ack", unit_ack, 5'b00001);
        tick();
        check("arst_first_unit",  wb_unit,  0);
        check("arst_first_valid", wb_valid, 1);

        // Stall counters: unit 1 waits behind a stalled port
        wb_ready  = 1'b0;
        unit_done = 5'b00010;
        #1;
        check("stall_ack", unit_ack, 0);
`ifdef WB_ARB_STALL_COUNT_EN
        repeat (70000) tick();
        check("stall_sat1", stall_count[1*SW +: SW], 16'hFFFF);
        check("stall_cnt0", stall_count[0*SW +: SW], 16'h0000);
        perf_clear = 1'b1;
        tick();
        perf_clear = 1'b0;
        check("stall_clear1", stall_count[1*SW +: SW], 16'h0000);
        tick();
        check("stall_restart1", stall_count[1*SW +: SW], 16'h0001);
`else
        repeat (5) tick();
        check("stall_tied0", stall_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_group_arbiter

`default_nettype wire
